instr_fetch_unit: RTL and testbench

Instruction fetch stage for the RISC-V core. It holds the PC and requests instructions from the instruction cache over a ready-based handshake, tolerating miss latency. It presents the latched instruction, including the [31:7] field consumed by the immediate sign-extender, and computes the next PC from the extended immediate or the JALR target. It also detects misaligned fetch targets and counts retired instructions.

---
 rtl/instr_fetch_unit.sv | 104 ++++++++++
 tb/tb_instr_fetch_unit.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: holds the PC, fetches over a ready handshake, computes the next PC,
// traps misaligned targets and counts retired instructions.
module instr_fetch_unit #(
  parameter int unsigned          BUS_WIDTH   = 32,
  parameter logic [BUS_WIDTH-1:0] RESET_PC    = 32'h0000_0000,
  parameter logic [BUS_WIDTH-1:0] RESET_INSTR = 32'h0000_0013
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_PCSrc,
  input  logic                 i_JalrSel,
  input  logic [BUS_WIDTH-1:0] i_ImmExt,
  input  logic [BUS_WIDTH-1:0] i_JalrTarget,
  input  logic                 i_Stall,
  output logic                 o_IReq,
  output logic [BUS_WIDTH-1:0] o_IAddr,
  input  logic                 i_IReady,
  input  logic [BUS_WIDTH-1:0] i_IData,
  output logic [BUS_WIDTH-1:0] o_PC,
  output logic [BUS_WIDTH-1:0] o_PCPlus4,
  output logic [BUS_WIDTH-1:0] o_Instr,
  output logic [BUS_WIDTH-1:7] o_ImmToBeExtended,
  output logic                 o_InstrValid,
  output logic                 o_Fault,
  output logic [31:0]          o_Retired
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StFetch = 2'd1;
  localparam logic [1:0] StExec  = 2'd2;
  localparam logic [1:0] StFault = 2'd3;

  logic [1:0]           state_q, state_d;
  logic [BUS_WIDTH-1:0] pc_q, pc_d;
  logic [BUS_WIDTH-1:0] instr_q, instr_d;
  logic [31:0]          retired_q, retired_d;
  logic [BUS_WIDTH-1:0] target;
  logic                 misaligned;

  // JALR wins over PC-relative; its bit 0 is dropped before the alignment test.
  always_comb begin
    if (i_JalrSel) begin
      target = {i_JalrTarget[BUS_WIDTH-1:1], 1'b0};
    end else if (i_PCSrc) begin
      target = pc_q + i_ImmExt;
    end else begin
      target = pc_q + BUS_WIDTH'(4);
    end
    misaligned = |target[1:0];
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    retired_d = retired_q;
    case (state_q)
      StIdle: state_d = StFetch;
      StFetch: begin
        if (i_IReady) begin
          instr_d = i_IData;
          state_d = StExec;
        end
      end
      StExec: begin
        if (!i_Stall) begin
          if (misaligned) begin
            state_d = StFault;
          end else begin
            pc_d      = target;
            retired_d = retired_q + 32'd1;
            state_d   = StFetch;
          end
        end
      end
      default: state_d = StFault;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= StIdle;
      pc_q      <= RESET_PC;
      instr_q   <= RESET_INSTR;
      retired_q <= 32'd0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      retired_q <= retired_d;
    end
  end

  assign o_IReq            = (state_q == StFetch);
  assign o_IAddr           = pc_q;
  assign o_PC              = pc_q;
  assign o_PCPlus4         = pc_q + BUS_WIDTH'(4);
  assign o_Instr           = instr_q;
  assign o_ImmToBeExtended = instr_q[BUS_WIDTH-1:7];
  assign o_InstrValid      = (state_q == StExec);
  assign o_Fault           = (state_q == StFault);
  assign o_Retired         = retired_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: driver pushes expected fetch addresses and executed
// instructions; a negedge monitor pops and compares when a request or valid instruction appears.
module tb_instr_fetch_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n = 1'b0;
  logic        pcsrc = 1'b0, jalr = 1'b0, stall = 1'b0, iready = 1'b0;
  logic [31:0] imm = '0, tgt = '0, idata = 32'h0000_0013;
  logic        ireq, ivalid, fault;
  logic [31:0] iaddr, pc, pcplus4, instr, retired;
  logic [31:7] immtbe;

  instr_fetch_unit u_dut (
    .i_clk             (clk),
    .i_rst_n           (rst_n),
    .i_PCSrc           (pcsrc),
    .i_JalrSel         (jalr),
    .i_ImmExt          (imm),
    .i_JalrTarget      (tgt),
    .i_Stall           (stall),
    .o_IReq            (ireq),
    .o_IAddr           (iaddr),
    .i_IReady          (iready),
    .i_IData           (idata),
    .o_PC              (pc),
    .o_PCPlus4         (pcplus4),
    .o_Instr           (instr),
    .o_ImmToBeExtended (immtbe),
    .o_InstrValid      (ivalid),
    .o_Fault           (fault),
    .o_Retired         (retired)
  );

  // Second instance starting just below the top of the address space.
  logic        rst_w = 1'b0;
  logic        w_req, w_valid, w_fault;
  logic [31:0] w_iaddr, w_pc, w_pcplus4, w_instr, w_ret;
  logic [31:7] w_imm;

  instr_fetch_unit #(
    .RESET_PC (32'hFFFF_FFFC)
  ) u_wrap (
    .i_clk             (clk),
    .i_rst_n           (rst_w),
    .i_PCSrc           (1'b0),
    .i_JalrSel         (1'b0),
    .i_ImmExt          (32'h0),
    .i_JalrTarget      (32'h0),
    .i_Stall           (1'b0),
    .o_IReq            (w_req),
    .o_IAddr           (w_iaddr),
    .i_IReady          (1'b1),
    .i_IData           (32'h0000_0013),
    .o_PC              (w_pc),
    .o_PCPlus4         (w_pcplus4),
    .o_Instr           (w_instr),
    .o_ImmToBeExtended (w_imm),
    .o_InstrValid      (w_valid),
    .o_Fault           (w_fault),
    .o_Retired         (w_ret)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] ret;
  } exec_t;

  exec_t       exp_exec[$];
  logic [31:0] exp_fetch[$];
  int          total = 0;
  int          bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Monitor: compare on each new request and each new valid instruction.
  logic prev_req = 1'b0, prev_valid = 1'b0;
  always @(negedge clk) begin
    if (ireq && !prev_req) begin
      if (exp_fetch.size() == 0) begin
        total++; bad++;
        $display("FAIL fetch_unexpected: got addr %h want no request", iaddr);
      end else begin
        check("fetch_addr", iaddr, exp_fetch.pop_front());
      end
    end
    if (ivalid && !prev_valid) begin
      if (exp_exec.size() == 0) begin
        total++; bad++;
        $display("FAIL exec_unexpected: got pc %h want no instruction", pc);
      end else begin
        exec_t e;
        e = exp_exec.pop_front();
        check("exec_pc", pc, e.pc);
        check("exec_instr", instr, e.instr);
        check("exec_retired", retired, e.ret);
        check("exec_imm", {7'd0, immtbe}, e.instr >> 7);
      end
    end
    prev_req   = ireq;
    prev_valid = ivalid;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Entered in a FETCH cycle; returns in the following EXEC cycle.
  task automatic fetch_one(input logic [31:0] addr, input logic [31:0] data, input int miss);
    for (int k = 0; k <= miss; k++) begin
      check("fetch_hold_addr", iaddr, addr);
      check("fetch_req", {31'd0, ireq}, 32'd1);
      check("fetch_novalid", {31'd0, ivalid}, 32'd0);
      if (k < miss) begin
        iready = 1'b0;
        idata  = 32'hDEAD_BEEF;
        step();
      end
    end
    iready = 1'b1;
    idata  = data;
    step();
    iready = 1'b0;
    idata  = 32'hDEAD_BEEF;
  endtask

  // Entered in an EXEC cycle; stalls nstall cycles, then commits with the given redirect.
  task automatic exec_one(input logic [31:0] epc, input logic [31:0] einstr,
                          input logic [31:0] eret, input int nstall, input logic s_pcsrc,
                          input logic s_jalr, input logic [31:0] s_imm, input logic [31:0] s_tgt);
    for (int k = 0; k <= nstall; k++) begin
      check("exec_valid", {31'd0, ivalid}, 32'd1);
      check("exec_noreq", {31'd0, ireq}, 32'd0);
      check("exec_hold_pc", pc, epc);
      check("exec_hold_instr", instr, einstr);
      check("exec_hold_ret", retired, eret);
      check("exec_pcplus4", pcplus4, epc + 32'd4);
      if (k < nstall) begin
        stall = 1'b1;
        jalr  = 1'b1;
        tgt   = 32'h0000_0003;
        step();
      end
    end
    stall = 1'b0;
    pcsrc = s_pcsrc;
    jalr  = s_jalr;
    imm   = s_imm;
    tgt   = s_tgt;
    step();
    pcsrc = 1'b0;
    jalr  = 1'b0;
    imm   = '0;
    tgt   = '0;
  endtask

  task automatic check_reset();
    check("rst_pc", pc, 32'h0);
    check("rst_instr", instr, 32'h0000_0013);
    check("rst_retired", retired, 32'h0);
    check("rst_req", {31'd0, ireq}, 32'd0);
    check("rst_valid", {31'd0, ivalid}, 32'd0);
    check("rst_fault", {31'd0, fault}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    step();
    step();
    check_reset();

    exp_fetch.push_back(32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("idle_noreq", {31'd0, ireq}, 32'd0);
    step();
    check("first_req", {31'd0, ireq}, 32'd1);

    // Sequential hits.
    for (int i = 0; i < 3; i++) begin
      exp_exec.push_back('{pc: 32'(4 * i), instr: 32'h13, ret: 32'(i)});
      fetch_one(32'(4 * i), 32'h13, 0);
      exp_fetch.push_back(32'(4 * i + 4));
      exec_one(32'(4 * i), 32'h13, 32'(i), 0, 1'b0, 1'b0, 32'h0, 32'h0);
    end
    check("retired_after_3", retired, 32'd3);
    check("pc_after_3", pc, 32'h0000_000C);

    exp_exec.push_back('{pc: 32'hC, instr: 32'h13, ret: 32'd3});
    fetch_one(32'hC, 32'h13, 0);
    exp_fetch.push_back(32'h10);
    exec_one(32'hC, 32'h13, 32'd3, 0, 1'b0, 1'b0, 32'h0, 32'h0);

    // Miss of 3 cycles, then 5 stall cycles, then PC-relative +0x10.
    exp_exec.push_back('{pc: 32'h10, instr: 32'hFE01_0113, ret: 32'd4});
    fetch_one(32'h10, 32'hFE01_0113, 3);
    check("imm_field", {7'd0, immtbe}, 32'h01FC_0202);
    exp_fetch.push_back(32'h20);
    exec_one(32'h10, 32'hFE01_0113, 32'd4, 5, 1'b1, 1'b0, 32'h10, 32'h0);
    check("retired_after_stall", retired, 32'd5);

    // Backward branch.
    exp_exec.push_back('{pc: 32'h20, instr: 32'h13, ret: 32'd5});
    fetch_one(32'h20, 32'h13, 0);
    exp_fetch.push_back(32'h18);
    exec_one(32'h20, 32'h13, 32'd5, 0, 1'b1, 1'b0, 32'hFFFF_FFF8, 32'h0);

    // JALR beats PC-relative, bit 0 cleared.
    exp_exec.push_back('{pc: 32'h18, instr: 32'h13, ret: 32'd6});
    fetch_one(32'h18, 32'h13, 0);
    exp_fetch.push_back(32'h40);
    exec_one(32'h18, 32'h13, 32'd6, 0, 1'b1, 1'b1, 32'h8, 32'h41);
    check("retired_after_jalr", retired, 32'd7);

    // Reset in the middle of a miss.
    iready = 1'b0;
    step();
    step();
    rst_n = 1'b0;
    #1;
    check_reset();
    step();

    exp_fetch.push_back(32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Misaligned PC-relative target traps.
    exp_exec.push_back('{pc: 32'h0, instr: 32'h13, ret: 32'd0});
    fetch_one(32'h0, 32'h13, 0);
    exec_one(32'h0, 32'h13, 32'd0, 0, 1'b1, 1'b0, 32'h6, 32'h0);
    iready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check("fault_set", {31'd0, fault}, 32'd1);
      check("fault_pc", pc, 32'h0);
      check("fault_retired", retired, 32'h0);
      check("fault_noreq", {31'd0, ireq}, 32'd0);
      check("fault_novalid", {31'd0, ivalid}, 32'd0);
      step();
    end
    iready = 1'b0;
    rst_n = 1'b0;
    #1;
    check_reset();

    // PC wraps from 0xFFFF_FFFC to 0.
    @(negedge clk);
    rst_w = 1'b1;
    step();
    check("wrap_req", {31'd0, w_req}, 32'd1);
    check("wrap_iaddr", w_iaddr, 32'hFFFF_FFFC);
    step();
    check("wrap_valid", {31'd0, w_valid}, 32'd1);
    check("wrap_pcplus4", w_pcplus4, 32'h0);
    check("wrap_instr", w_instr, 32'h13);
    check("wrap_imm", {7'd0, w_imm}, 32'h0);
    step();
    check("wrap_pc", w_pc, 32'h0);
    check("wrap_fault", {31'd0, w_fault}, 32'd0);
    check("wrap_retired", w_ret, 32'd1);
    check("wrap_req2", {31'd0, w_req}, 32'd1);

    step();
    check("fetch_queue_empty", 32'(exp_fetch.size()), 32'd0);
    check("exec_queue_empty", 32'(exp_exec.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
